// File: rtl/plru_pkg.sv
// Tree-PLRU helpers shared by the L1D blocks.
// Trees are heap-indexed: node n lives in bit n-1, root is node 1.
package plru_pkg;

  localparam int MAX_WAY_W = 6;
  localparam int MAX_LRU_W = 63;

  typedef logic [MAX_LRU_W-1:0] plru_tree_t;
  typedef logic [MAX_WAY_W-1:0] plru_way_t;

  function automatic int lru_w(int nway);
    return nway - 1;
  endfunction

  function automatic int way_w(int nway);
    return (nway < 2) ? 1 : $clog2(nway);
  endfunction

  function automatic logic is_pow2(int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Follow the bits from the root; the bits taken form the way, root = MSB.
  function automatic plru_way_t plru_walk(plru_tree_t t, int lvls);
    logic [6:0] n;
    logic       b;
    plru_way_t  w;
    n = 7'd1;
    w = '0;
    for (int l = 0; l < MAX_WAY_W; l++) begin
      if (l < lvls) begin
        b = t[n[5:0] - 6'd1];
        w = {w[MAX_WAY_W-2:0], b};
        n = {n[5:0], b};
      end
    end
    return w;
  endfunction

  // Point every node on the way's path away from that way.
  function automatic plru_tree_t plru_touch(plru_tree_t t, plru_way_t way,
                                            int lvls);
    logic [6:0] n;
    logic       b;
    plru_way_t  s;
    plru_tree_t r;
    n = 7'd1;
    r = t;
    s = way << (MAX_WAY_W - lvls);
    for (int l = 0; l < MAX_WAY_W; l++) begin
      if (l < lvls) begin
        b = s[MAX_WAY_W-1];
        r[n[5:0] - 6'd1] = ~b;
        n = {n[5:0], b};
        s = s << 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_repl_array_if.sv
// Touch / allocate / victim bundle of the PLRU replacement store.
// master drives requests, slave returns the registered victim.
interface plru_repl_array_if
  import plru_pkg::*;
#(
  parameter int NSET = 64,
  parameter int NWAY = 8
);
  localparam int SET_W = $clog2(NSET);
  localparam int WAY_W = way_w(NWAY);

  logic             touch_vld_i;
  logic [SET_W-1:0] touch_set_i;
  logic [WAY_W-1:0] touch_way_i;
  logic             alloc_vld_i;
  logic [SET_W-1:0] alloc_set_i;
  logic [NWAY-1:0]  alloc_inv_mask_i;
  logic             victim_vld_o;
  logic [WAY_W-1:0] victim_way_o;
  logic [SET_W-1:0] victim_set_o;

  modport master (
    output touch_vld_i, touch_set_i, touch_way_i,
    output alloc_vld_i, alloc_set_i, alloc_inv_mask_i,
    input  victim_vld_o, victim_way_o, victim_set_o
  );

  modport slave (
    input  touch_vld_i, touch_set_i, touch_way_i,
    input  alloc_vld_i, alloc_set_i, alloc_inv_mask_i,
    output victim_vld_o, victim_way_o, victim_set_o
  );

endinterface

// File: rtl/plru_tree_upd.sv
// Combinational victim select and touch update for one PLRU tree.
// force_i overrides the walked victim with force_way_i.
module plru_tree_upd
  import plru_pkg::*;
#(
  parameter  int NWAY  = 8,
  localparam int LRU_W = lru_w(NWAY),
  localparam int WAY_W = way_w(NWAY)
) (
  input  logic [LRU_W-1:0] tree_i,
  input  logic             upd_i,
  input  logic             force_i,
  input  logic [WAY_W-1:0] force_way_i,
  output logic [WAY_W-1:0] way_o,
  output logic [LRU_W-1:0] tree_o
);

  plru_tree_t tree_ext;
  plru_tree_t tree_new;
  plru_way_t  walk_way;
  plru_way_t  sel_way;
  logic       unused_bits;

  // Pick the way, then point its path away from it.
  always_comb begin
    tree_ext = plru_tree_t'(tree_i);
    walk_way = plru_walk(tree_ext, WAY_W);
    sel_way  = force_i ? plru_way_t'(force_way_i) : walk_way;
    tree_new = plru_touch(tree_ext, sel_way, WAY_W);
  end

  assign way_o  = sel_way[WAY_W-1:0];
  assign tree_o = upd_i ? tree_new[LRU_W-1:0] : tree_i;

  assign unused_bits = ^{tree_new, sel_way, walk_way};

endmodule

// File: rtl/plru_repl_array.sv
// Per-set tree-PLRU state for the L1D with a registered victim port.
// Allocs prefer invalid ways; same-set touches bypass into the alloc.
module plru_repl_array
  import plru_pkg::*;
#(
  parameter  int NSET  = 64,
  parameter  int NWAY  = 8,
  localparam int SET_W = $clog2(NSET),
  localparam int WAY_W = way_w(NWAY),
  localparam int LRU_W = lru_w(NWAY)
) (
  input logic             clk,
  input logic             rst,
  plru_repl_array_if.slave bus
);

  if (!is_pow2(NWAY) || NWAY > 64) begin : g_bad_nway
    $error("plru_repl_array: NWAY must be a power of 2 in 2..64");
  end
  if (!is_pow2(NSET)) begin : g_bad_nset
    $error("plru_repl_array: NSET must be a power of 2 >= 2");
  end

  logic [LRU_W-1:0] trees_q [NSET];
  logic [LRU_W-1:0] trees_d [NSET];
  logic             vld_q, vld_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [SET_W-1:0] set_q, set_d;

  logic [LRU_W-1:0] touch_cur;
  logic [LRU_W-1:0] touch_nxt;
  logic [LRU_W-1:0] alloc_base;
  logic [LRU_W-1:0] alloc_nxt;
  logic [WAY_W-1:0] alloc_way;
  logic [WAY_W-1:0] inv_way;
  logic             inv_any;
  logic             same_set;
  logic [WAY_W-1:0] unused_touch_way;

  assign touch_cur = trees_q[bus.touch_set_i];
  assign same_set  = bus.touch_vld_i &&
                     (bus.touch_set_i == bus.alloc_set_i);
  assign alloc_base = same_set ? touch_nxt
                               : trees_q[bus.alloc_set_i];

  plru_tree_upd #(.NWAY(NWAY)) u_touch (
    .tree_i      (touch_cur),
    .upd_i       (bus.touch_vld_i),
    .force_i     (1'b1),
    .force_way_i (bus.touch_way_i),
    .way_o       (unused_touch_way),
    .tree_o      (touch_nxt)
  );

  // Lowest-index invalid way wins over the PLRU walk.
  always_comb begin
    inv_way = '0;
    inv_any = |bus.alloc_inv_mask_i;
    for (int i = NWAY - 1; i >= 0; i--) begin
      if (bus.alloc_inv_mask_i[i]) inv_way = WAY_W'(i);
    end
  end

  plru_tree_upd #(.NWAY(NWAY)) u_alloc (
    .tree_i      (alloc_base),
    .upd_i       (bus.alloc_vld_i),
    .force_i     (inv_any),
    .force_way_i (inv_way),
    .way_o       (alloc_way),
    .tree_o      (alloc_nxt)
  );

  // Next state: touch first, alloc (already bypassed) last.
  always_comb begin
    trees_d = trees_q;
    if (bus.touch_vld_i) trees_d[bus.touch_set_i] = touch_nxt;
    if (bus.alloc_vld_i) trees_d[bus.alloc_set_i] = alloc_nxt;
    vld_d = bus.alloc_vld_i;
    way_d = bus.alloc_vld_i ? alloc_way : way_q;
    set_d = bus.alloc_vld_i ? bus.alloc_set_i : set_q;
  end

  // State and victim registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSET; i++) trees_q[i] <= '0;
      vld_q <= 1'b0;
      way_q <= '0;
      set_q <= '0;
    end else begin
      trees_q <= trees_d;
      vld_q   <= vld_d;
      way_q   <= way_d;
      set_q   <= set_d;
    end
  end

  assign bus.victim_vld_o = vld_q & ~rst;
  assign bus.victim_way_o = rst ? '0 : way_q;
  assign bus.victim_set_o = rst ? '0 : set_q;

endmodule

// File: tb/tb_plru_repl_array.sv
// Directed and seeded-random checks of plru_repl_array.
// Outputs are sampled 1 ns after the rising edge.
module tb_plru_repl_array;
  import plru_pkg::*;

  localparam int NSET  = 64;
  localparam int NWAY  = 8;
  localparam int SET_W = 6;
  localparam int WAY_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  plru_repl_array_if #(.NSET(NSET), .NWAY(NWAY)) bus ();

  plru_repl_array #(.NSET(NSET), .NWAY(NWAY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic tv, input int ts, input int tw,
                     input logic av, input int as, input logic [7:0] m);
    bus.touch_vld_i      = tv;
    bus.touch_set_i      = ts[SET_W-1:0];
    bus.touch_way_i      = tw[WAY_W-1:0];
    bus.alloc_vld_i      = av;
    bus.alloc_set_i      = as[SET_W-1:0];
    bus.alloc_inv_mask_i = m;
    @(posedge clk);
    #1;
  endtask

  task automatic expv(input string tag, input logic v, input int w,
                      input int s);
    chk({tag, ".vld"}, 32'(bus.victim_vld_o), 32'(v));
    chk({tag, ".way"}, 32'(bus.victim_way_o), w[31:0]);
    chk({tag, ".set"}, 32'(bus.victim_set_o), s[31:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 0, 0, 1'b0, 0, 8'h00);
    cyc(1'b0, 0, 0, 1'b0, 0, 8'h00);
    rst = 1'b0;
  endtask

  logic [6:0] mt [NSET];

  initial begin
    int seq [9];
    seq = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

    do_reset();
    expv("reset", 1'b0, 0, 0);

    // Plain PLRU rotation in one set.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 0, 0, 1'b1, 0, 8'h00);
      expv($sformatf("rot%0d", i), 1'b1, seq[i], 0);
    end
    cyc(1'b0, 0, 0, 1'b0, 0, 8'h00);
    chk("rot_idle.vld", 32'(bus.victim_vld_o), 32'd0);

    // Touch steers the following alloc; sets are independent.
    do_reset();
    cyc(1'b1, 3, 0, 1'b0, 0, 8'h00);
    chk("touch_only.vld", 32'(bus.victim_vld_o), 32'd0);
    cyc(1'b0, 0, 0, 1'b1, 3, 8'h00);
    expv("touch_then_alloc", 1'b1, 4, 3);
    cyc(1'b0, 0, 0, 1'b1, 5, 8'h00);
    expv("other_set", 1'b1, 0, 5);

    // Invalid way preferred, tree then reflects a touch of way 5.
    cyc(1'b0, 0, 0, 1'b1, 1, 8'hA0);
    expv("inv_pick", 1'b1, 5, 1);
    cyc(1'b0, 0, 0, 1'b1, 1, 8'h00);
    expv("after_inv", 1'b1, 0, 1);
    cyc(1'b0, 0, 0, 1'b1, 1, 8'h00);
    expv("after_inv2", 1'b1, 6, 1);

    // Same-set touch bypasses into the alloc.
    do_reset();
    cyc(1'b1, 2, 0, 1'b1, 2, 8'h00);
    expv("bypass", 1'b1, 4, 2);
    cyc(1'b0, 0, 0, 1'b1, 2, 8'h00);
    expv("bypass_next", 1'b1, 2, 2);
    cyc(1'b0, 0, 0, 1'b0, 0, 8'h00);
    expv("hold", 1'b0, 2, 2);

    // Reset right after an alloc kills its victim pulse.
    cyc(1'b0, 0, 0, 1'b1, 6, 8'h00);
    expv("pre_rst_a", 1'b1, 0, 6);
    cyc(1'b0, 0, 0, 1'b1, 6, 8'h00);
    rst = 1'b1;
    #1;
    expv("rst_suppress", 1'b0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dominates.vld", 32'(bus.victim_vld_o), 32'd0);
    cyc(1'b0, 0, 0, 1'b1, 6, 8'h00);
    expv("post_rst", 1'b1, 0, 6);

    // Seeded random traffic on a few sets against the package model.
    do_reset();
    for (int i = 0; i < NSET; i++) mt[i] = '0;
    for (int k = 0; k < 200; k++) begin
      logic       tv, av;
      int         ts, tw, as, ew;
      logic [7:0] m;
      plru_tree_t t;
      plru_way_t  w;
      tv = 1'($urandom_range(0, 1));
      av = 1'($urandom_range(0, 1));
      ts = $urandom_range(0, 3);
      tw = $urandom_range(0, 7);
      as = $urandom_range(0, 3);
      m  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ew = 0;
      if (tv) begin
        t = plru_touch(plru_tree_t'(mt[ts]), plru_way_t'(tw), 3);
        mt[ts] = t[6:0];
      end
      if (av) begin
        if (m != 8'h00) begin
          ew = -1;
          for (int j = 7; j >= 0; j--) if (m[j]) ew = j;
        end else begin
          w  = plru_walk(plru_tree_t'(mt[as]), 3);
          ew = int'(w);
        end
        t = plru_touch(plru_tree_t'(mt[as]), plru_way_t'(ew), 3);
        mt[as] = t[6:0];
      end
      cyc(tv, ts, tw, av, as, m);
      chk($sformatf("rnd%0d.vld", k), 32'(bus.victim_vld_o), 32'(av));
      if (av) begin
        chk($sformatf("rnd%0d.way", k), 32'(bus.victim_way_o), ew[31:0]);
        chk($sformatf("rnd%0d.set", k), 32'(bus.victim_set_o), as[31:0]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
